shim_decoder: RTL

PWM measurement block for the Barker-11 control path: the receive-side counterpart to the PWM generator that encodes two 4-bit codes as a low-phase and a high-phase duration of 4·code clocks. It samples an incoming PWM line and measures each low phase and each following high phase. It recovers the two 4-bit codes and emits them with a one-cycle valid strobe per completed period. It flags a stuck line when no edge arrives within a timeout.

---
 rtl/shim_pkg.sv | 25 ++
 rtl/shim_dec_sync.sv | 75 +++++++
 rtl/shim_decoder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/shim_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shim_pkg
// Brief    : Shared constants and FSM state encoding for the Barker-11 PWM
//            shim (generator and decoder agree on code width and step size).
// Revision : 1.0 - initial release
// ============================================================================
package shim_pkg;

  // Width of each PWM code carried in one phase.
  localparam int unsigned CODE_W    = 4;
  // Clocks of phase length per code unit.
  localparam int unsigned CODE_STEP = 4;
  // Largest representable code; longer phases saturate here.
  localparam int unsigned CODE_MAX  = 15;

  // Decoder measurement state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } shim_state_e;

endpackage
`default_nettype wire

// File: rtl/shim_dec_sync.sv
`default_nettype none
// ============================================================================
// Module   : shim_dec_sync
// Brief    : Input conditioning for the PWM decoder: synchronizer chain,
//            optional 3-sample majority filter, registered rise/fall pulses.
//            Optional feature macro: SHIM_DEC_GLITCH_FILTER_EN
//            (defined -> majority filter in path, +2 cycles latency).
// Revision : 1.0 - initial release
// ============================================================================
module shim_dec_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_s;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;

  // Shift the asynchronous line through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
    end
  end

`ifdef SHIM_DEC_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;
  logic       sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Registered majority vote over the three most recent synchronized samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], sync_s};
      filt_q <= (sync_s & hist_q[0]) | (sync_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end
  end

  assign level_s = filt_q;
`else
  assign level_s = sync_q[SYNC_STAGES-1];
`endif

  // Compare the conditioned line with its previous value to produce edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= level_s;
      rise_q  <= level_s & ~level_q;
      fall_q  <= ~level_s & level_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule
`default_nettype wire

// File: rtl/shim_decoder.sv
`default_nettype none
// ============================================================================
// Module   : shim_decoder
// Brief    : Receive-side PWM measurement for the Barker-11 control path.
//            Measures each low phase and the following high phase, quantizes
//            both lengths to 4-bit codes and strobes valid once per period.
//            Flags a stuck line when a level outlasts TIMEOUT cycles.
//            Optional feature macro: SHIM_DEC_GLITCH_FILTER_EN (see
//            shim_dec_sync).
// Revision : 1.0 - initial release
// ============================================================================
module shim_decoder
  import shim_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [CODE_W-1:0] low_code,
  output logic [CODE_W-1:0] high_code,
  output logic              valid,
  output logic              stuck_lo,
  output logic              stuck_hi
);

  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam int               STEP_SHIFT = $clog2(CODE_STEP);

  // Round len to the nearest code step (ties at 4N-2 go up), clamp at CODE_MAX.
  // One extra bit keeps the +2 rounding term from wrapping near saturation.
  function automatic logic [CODE_W-1:0] quantize(input logic [CNT_W-1:0] len);
    logic [CNT_W:0] rounded;
    rounded = ({1'b0, len} + (CNT_W+1)'(CODE_STEP / 2)) >> STEP_SHIFT;
    if (rounded > (CNT_W+1)'(CODE_MAX)) begin
      quantize = CODE_W'(CODE_MAX);
    end else begin
      quantize = rounded[CODE_W-1:0];
    end
  endfunction

  logic              rise_s;
  logic              fall_s;
  logic [CNT_W-1:0]  cnt_inc;

  shim_state_e       state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  low_len_q;
  logic [CODE_W-1:0] low_code_q;
  logic [CODE_W-1:0] high_code_q;
  logic              valid_q;
  logic              stuck_lo_q;
  logic              stuck_hi_q;

  shim_dec_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .pwm_i  (pwm_in),
    .rise_o (rise_s),
    .fall_o (fall_s)
  );

  // Phase counter saturates instead of wrapping.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

  // Measurement FSM: edges take priority over timeout in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      low_len_q   <= '0;
      low_code_q  <= '0;
      high_code_q <= '0;
      valid_q     <= 1'b0;
      stuck_lo_q  <= 1'b0;
      stuck_hi_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise_s || fall_s) begin
            stuck_lo_q <= 1'b0;
            stuck_hi_q <= 1'b0;
          end
          if (fall_s) begin
            cnt_q   <= CNT_ONE;
            state_q <= LOW;
          end
        end
        LOW: begin
          if (rise_s) begin
            low_len_q <= cnt_q;
            cnt_q     <= CNT_ONE;
            state_q   <= HIGH;
          end else if (cnt_q == TIMEOUT_C) begin
            stuck_lo_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        HIGH: begin
          if (fall_s) begin
            low_code_q  <= quantize(low_len_q);
            high_code_q <= quantize(cnt_q);
            valid_q     <= 1'b1;
            cnt_q       <= CNT_ONE;
            state_q     <= LOW;
          end else if (cnt_q == TIMEOUT_C) begin
            stuck_hi_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign low_code  = low_code_q;
  assign high_code = high_code_q;
  assign valid     = valid_q;
  assign stuck_lo  = stuck_lo_q;
  assign stuck_hi  = stuck_hi_q;

endmodule
`default_nettype wire
